// File: rtl/snappy_job_pkg.sv
// Shared types for the Snappy job dispatcher: descriptor layout, completion
// status codes and dispatcher FSM states.
package snappy_job_pkg;

   // Tag storage width inside a queued descriptor; TAG_W must not exceed it.
   localparam int DESC_TAG_W = 8;

   typedef struct packed {
      logic [63:0]           src;
      logic [63:0]           des;
      logic [34:0]           comp_len;
      logic [31:0]           decomp_len;
      logic [DESC_TAG_W-1:0] tag;
   } desc_t;

   localparam logic [1:0] STS_OK       = 2'b00;
   localparam logic [1:0] STS_ZERO_LEN = 2'b01;
   localparam logic [1:0] STS_TIMEOUT  = 2'b10;

   typedef enum logic [2:0] {IDLE, LAUNCH, RUN, DRAIN, REPORT} state_t;

endpackage

// File: rtl/snappy_job_dispatcher_if.sv
// Bundles the job-submit, core-control and completion signals of the dispatcher.
// master = dispatcher side, slave = host/core environment side.
interface snappy_job_dispatcher_if #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 8
);
   logic                     job_valid;
   logic                     job_ready;
   logic [63:0]              job_src_addr;
   logic [63:0]              job_des_addr;
   logic [34:0]              job_comp_len;
   logic [31:0]              job_decomp_len;
   logic [TAG_W-1:0]         job_tag;
   logic                     start;
   logic [63:0]              src_addr;
   logic [63:0]              des_addr;
   logic [34:0]              compression_length;
   logic [31:0]              decompression_length;
   logic                     done;
   logic                     idle;
   logic                     abort;
   logic                     cpl_valid;
   logic                     cpl_ready;
   logic [TAG_W-1:0]         cpl_tag;
   logic [1:0]               cpl_status;
   logic [$clog2(DEPTH):0]   pending;
   logic                     busy;

   modport master (
      input  job_valid, job_src_addr, job_des_addr, job_comp_len, job_decomp_len, job_tag,
      input  done, idle, cpl_ready,
      output job_ready, start, src_addr, des_addr, compression_length, decompression_length,
      output abort, cpl_valid, cpl_tag, cpl_status, pending, busy
   );

   modport slave (
      output job_valid, job_src_addr, job_des_addr, job_comp_len, job_decomp_len, job_tag,
      output done, idle, cpl_ready,
      input  job_ready, start, src_addr, des_addr, compression_length, decompression_length,
      input  abort, cpl_valid, cpl_tag, cpl_status, pending, busy
   );
endinterface

// File: rtl/job_desc_fifo.sv
// Synchronous descriptor FIFO with occupancy count; head is read combinationally
// so the dispatcher can classify and capture it in the dequeue cycle.
module job_desc_fifo
   import snappy_job_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   srst,
   input  logic                   wr_en,
   input  desc_t                  wr_data,
   input  logic                   rd_en,
   output desc_t                  rd_data,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);

   desc_t            mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_reg] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (wr_en) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (rd_en) rd_ptr_reg <= rd_ptr_reg + 1'b1;
         count_reg <= count_reg + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      end
   end

   assign rd_data = mem[rd_ptr_reg];
   assign count   = count_reg;
endmodule

// File: rtl/snappy_job_dispatcher.sv
// Queues Snappy job descriptors and runs them one at a time on the decompressor.
// Optional watchdog with core abort: define JOB_TIMEOUT_EN.
module snappy_job_dispatcher
   import snappy_job_pkg::*;
#(
   parameter int DEPTH          = 4,
   parameter int TAG_W          = 8,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input logic                     clk,
   input logic                     rst,
   snappy_job_dispatcher_if.master bus
);
   localparam int CW = $clog2(DEPTH) + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TAG_W > DESC_TAG_W || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("snappy_job_dispatcher: illegal parameterisation");
   end

   state_t           state_reg, state_next;
   desc_t            wr_desc, head;
   logic [CW-1:0]    count;
   logic             enq, deq, zero_len, tmo_hit;
   logic [63:0]      src_reg, des_reg;
   logic [34:0]      comp_reg;
   logic [31:0]      decomp_reg;
   logic [TAG_W-1:0] tag_reg;
   logic [1:0]       status_reg;

   assign bus.job_ready = (count != CW'(DEPTH));
   assign enq           = bus.job_valid && bus.job_ready;
   assign wr_desc       = '{src: bus.job_src_addr, des: bus.job_des_addr,
                            comp_len: bus.job_comp_len, decomp_len: bus.job_decomp_len,
                            tag: DESC_TAG_W'(bus.job_tag)};

   job_desc_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .srst    (rst),
      .wr_en   (enq),
      .wr_data (wr_desc),
      .rd_en   (deq),
      .rd_data (head),
      .count   (count)
   );

   assign zero_len = (head.comp_len == '0) || (head.decomp_len == '0);

`ifdef JOB_TIMEOUT_EN
   logic [31:0] tmo_cnt_reg;

   // Held at zero outside RUN, so it restarts from zero on every RUN entry.
   always_ff @(posedge clk) begin
      if (rst || state_reg != RUN) tmo_cnt_reg <= '0;
      else                         tmo_cnt_reg <= tmo_cnt_reg + 32'd1;
   end

   assign tmo_hit = (state_reg == RUN) && !bus.done && (tmo_cnt_reg == 32'(TIMEOUT_CYCLES - 1));
`else
   assign tmo_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      deq        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (count != '0 && bus.idle) begin
               deq        = 1'b1;
               state_next = zero_len ? REPORT : LAUNCH;
            end
         end
         LAUNCH: state_next = RUN;
         RUN:    if (bus.done || tmo_hit) state_next = DRAIN;
         DRAIN:  if (bus.idle) state_next = REPORT;
         REPORT: if (bus.cpl_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         src_reg    <= '0;
         des_reg    <= '0;
         comp_reg   <= '0;
         decomp_reg <= '0;
         tag_reg    <= '0;
         status_reg <= STS_OK;
      end else if (deq) begin
         src_reg    <= head.src;
         des_reg    <= head.des;
         comp_reg   <= head.comp_len;
         decomp_reg <= head.decomp_len;
         tag_reg    <= TAG_W'(head.tag);
         status_reg <= zero_len ? STS_ZERO_LEN : STS_OK;
      end else if (tmo_hit) begin
         status_reg <= STS_TIMEOUT;
      end
   end

   assign bus.start                = (state_reg == LAUNCH);
   assign bus.abort                = tmo_hit;
   assign bus.cpl_valid            = (state_reg == REPORT);
   assign bus.cpl_tag              = tag_reg;
   assign bus.cpl_status           = status_reg;
   assign bus.src_addr             = src_reg;
   assign bus.des_addr             = des_reg;
   assign bus.compression_length   = comp_reg;
   assign bus.decompression_length = decomp_reg;
   assign bus.pending              = count;
   assign bus.busy                 = (state_reg != IDLE) || (count != '0);
endmodule

// File: tb/tb_snappy_job_dispatcher.sv
// Directed self-checking bench for snappy_job_dispatcher with a behavioural core model.
// The watchdog scenario is exercised only when JOB_TIMEOUT_EN is defined.
module tb_snappy_job_dispatcher;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   snappy_job_dispatcher_if #(.DEPTH(4), .TAG_W(8)) bus ();

   snappy_job_dispatcher #(.DEPTH(4), .TAG_W(8), .TIMEOUT_CYCLES(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // Core model: busy for core_lat cycles after start (0 = never finishes),
   // pulses done, then raises idle the following cycle.
   logic core_idle, core_done, core_hold;
   int   core_cnt, core_lat;
   assign bus.done = core_done;
   assign bus.idle = core_idle && !core_hold;

   always @(posedge clk) begin
      if (rst) begin
         core_idle <= 1'b1;
         core_done <= 1'b0;
         core_cnt  <= 0;
      end else begin
         core_done <= 1'b0;
         if (core_done) core_idle <= 1'b1;
         if (bus.start) begin
            core_idle <= 1'b0;
            core_cnt  <= core_lat;
         end else if (bus.abort) begin
            core_idle <= 1'b1;
            core_cnt  <= 0;
         end else if (core_cnt != 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) core_done <= 1'b1;
         end
      end
   end

   int         cyc = 0;
   int         start_count = 0, abort_count = 0, viol = 0, start_cyc = 0, abort_cyc = 0;
   logic [7:0] tag_q[$];
   logic [1:0] sts_q[$];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         if (bus.start) begin
            start_count <= start_count + 1;
            start_cyc   <= cyc;
            if (!bus.idle) viol <= viol + 1;
         end
         if (bus.abort) begin
            abort_count <= abort_count + 1;
            abort_cyc   <= cyc;
         end
         if (bus.cpl_valid && bus.cpl_ready) begin
            tag_q.push_back(bus.cpl_tag);
            sts_q.push_back(bus.cpl_status);
            $display("cpl tag=%02h status=%0d", bus.cpl_tag, bus.cpl_status);
         end
      end
   end

   task automatic enq(input logic [63:0] s, input logic [63:0] d, input logic [34:0] c,
                      input logic [31:0] dl, input logic [7:0] t);
      int n = 0;
      @(negedge clk);
      bus.job_src_addr   = s;
      bus.job_des_addr   = d;
      bus.job_comp_len   = c;
      bus.job_decomp_len = dl;
      bus.job_tag        = t;
      bus.job_valid      = 1'b1;
      while (bus.job_ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000) begin
         chk_cnt++;
         $display("FAIL enq_ready tag=%02h: job_ready=%b, required 1", t, bus.job_ready);
      end
      @(posedge clk);
      #1 bus.job_valid = 1'b0;
      $display("enq tag=%02h src=%h comp=%0d decomp=%0d", t, s, c, dl);
   endtask

   task automatic wait_cpl(input int target);
      int n = 0;
      while (tag_q.size() < target && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk_cnt++;
      if (tag_q.size() < target)
         $display("FAIL cpl_wait: got %0d completions, required %0d", tag_q.size(), target);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_cnt++; if (bus.job_ready !== 1'b1) $display("FAIL rst_job_ready: %b, required 1", bus.job_ready); else pass_cnt++;
      chk_cnt++; if (bus.start !== 1'b0) $display("FAIL rst_start: %b, required 0", bus.start); else pass_cnt++;
      chk_cnt++; if (bus.cpl_valid !== 1'b0) $display("FAIL rst_cpl_valid: %b, required 0", bus.cpl_valid); else pass_cnt++;
      chk_cnt++; if (bus.pending !== 3'd0) $display("FAIL rst_pending: %0d, required 0", bus.pending); else pass_cnt++;
      chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: %b, required 0", bus.busy); else pass_cnt++;
      chk_cnt++; if (bus.abort !== 1'b0) $display("FAIL rst_abort: %b, required 0", bus.abort); else pass_cnt++;
      chk_cnt++; if (bus.src_addr !== 64'd0 || bus.cpl_tag !== 8'd0 || bus.cpl_status !== 2'd0)
         $display("FAIL rst_regs: src=%h tag=%h sts=%0d, required 0/0/0", bus.src_addr, bus.cpl_tag, bus.cpl_status);
      else pass_cnt++;
      rst = 1'b0;
   endtask

   task automatic test_single_job();
      int b = tag_q.size();
      int s0 = start_count;
      core_lat = 100;
      enq(64'h1000, 64'h8000, 35'd5000, 32'd65536, 8'h3A);
      wait_cpl(b + 1);
      @(negedge clk);
      chk_cnt++; if (start_count - s0 !== 1) $display("FAIL single_starts: %0d, required 1", start_count - s0); else pass_cnt++;
      chk_cnt++; if (tag_q[b] !== 8'h3A || sts_q[b] !== 2'd0)
         $display("FAIL single_cpl: tag=%02h sts=%0d, required 3a/0", tag_q[b], sts_q[b]); else pass_cnt++;
      chk_cnt++; if (bus.src_addr !== 64'h1000 || bus.des_addr !== 64'h8000 ||
                     bus.compression_length !== 35'd5000 || bus.decompression_length !== 32'd65536)
         $display("FAIL single_core_fields: src=%h des=%h comp=%0d decomp=%0d, required 1000/8000/5000/65536",
                  bus.src_addr, bus.des_addr, bus.compression_length, bus.decompression_length);
      else pass_cnt++;
      chk_cnt++; if (bus.busy !== 1'b0) $display("FAIL single_busy_after: %b, required 0", bus.busy); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      int b = tag_q.size();
      int s0 = start_count;
      core_lat  = 20;
      core_hold = 1'b1;
      for (int i = 0; i < 4; i++) enq(64'h100 * i, 64'h4000 + i, 35'd64, 32'd128, 8'(i));
      @(negedge clk);
      chk_cnt++; if (bus.pending !== 3'd4) $display("FAIL b2b_pending_full: %0d, required 4", bus.pending); else pass_cnt++;
      chk_cnt++; if (bus.job_ready !== 1'b0) $display("FAIL b2b_ready_full: %b, required 0", bus.job_ready); else pass_cnt++;
      chk_cnt++; if (bus.busy !== 1'b1) $display("FAIL b2b_busy: %b, required 1", bus.busy); else pass_cnt++;
      chk_cnt++; if (start_count != s0) $display("FAIL b2b_start_while_held: %0d, required 0", start_count - s0); else pass_cnt++;
      core_hold = 1'b0;
      enq(64'h400, 64'h4004, 35'd64, 32'd128, 8'd4);
      wait_cpl(b + 5);
      for (int i = 0; i < 5; i++) begin
         chk_cnt++;
         if (tag_q[b+i] !== 8'(i) || sts_q[b+i] !== 2'd0)
            $display("FAIL b2b_order[%0d]: tag=%02h sts=%0d, required %02h/0", i, tag_q[b+i], sts_q[b+i], i);
         else pass_cnt++;
      end
      chk_cnt++; if (start_count - s0 !== 5) $display("FAIL b2b_starts: %0d, required 5", start_count - s0); else pass_cnt++;
      chk_cnt++; if (viol !== 0) $display("FAIL b2b_start_not_idle: %0d, required 0", viol); else pass_cnt++;
   endtask

   task automatic test_zero_len();
      int b = tag_q.size();
      int s0 = start_count;
      core_lat = 8;
      enq(64'h2000, 64'h9000, 35'd0, 32'd4096, 8'h07);
      enq(64'h3000, 64'hA000, 35'd100, 32'd200, 8'h08);
      wait_cpl(b + 2);
      chk_cnt++; if (tag_q[b] !== 8'h07 || sts_q[b] !== 2'd1)
         $display("FAIL zero_len_cpl: tag=%02h sts=%0d, required 07/1", tag_q[b], sts_q[b]); else pass_cnt++;
      chk_cnt++; if (tag_q[b+1] !== 8'h08 || sts_q[b+1] !== 2'd0)
         $display("FAIL zero_len_next: tag=%02h sts=%0d, required 08/0", tag_q[b+1], sts_q[b+1]); else pass_cnt++;
      chk_cnt++; if (start_count - s0 !== 1) $display("FAIL zero_len_starts: %0d, required 1", start_count - s0); else pass_cnt++;
      chk_cnt++; if (bus.compression_length !== 35'd100) $display("FAIL zero_len_hold: %0d, required 100", bus.compression_length); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      int b = tag_q.size();
      int s0 = start_count;
      int n = 0;
      int unstable = 0;
      core_lat      = 10;
      bus.cpl_ready = 1'b0;
      enq(64'h5000, 64'hB000, 35'd10, 32'd20, 8'h11);
      enq(64'h6000, 64'hC000, 35'd30, 32'd40, 8'h12);
      while (bus.cpl_valid !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk_cnt++; if (bus.cpl_valid !== 1'b1) $display("FAIL bp_cpl_valid: %b, required 1", bus.cpl_valid); else pass_cnt++;
      repeat (50) begin
         @(negedge clk);
         if (bus.cpl_valid !== 1'b1 || bus.cpl_tag !== 8'h11 || bus.cpl_status !== 2'd0) unstable++;
      end
      chk_cnt++; if (unstable !== 0) $display("FAIL bp_stable: %0d unstable cycles, required 0", unstable); else pass_cnt++;
      chk_cnt++; if (start_count - s0 !== 1) $display("FAIL bp_no_launch: %0d starts, required 1", start_count - s0); else pass_cnt++;
      chk_cnt++; if (bus.pending !== 3'd1) $display("FAIL bp_pending: %0d, required 1", bus.pending); else pass_cnt++;
      bus.cpl_ready = 1'b1;
      wait_cpl(b + 2);
      chk_cnt++; if (tag_q[b] !== 8'h11 || tag_q[b+1] !== 8'h12)
         $display("FAIL bp_order: %02h,%02h, required 11,12", tag_q[b], tag_q[b+1]); else pass_cnt++;
   endtask

   task automatic test_reset_mid_job();
      int b = tag_q.size();
      int s0 = start_count;
      int n = 0;
      core_lat = 200;
      enq(64'h7000, 64'hD000, 35'd50, 32'd60, 8'h55);
      enq(64'h7100, 64'hD100, 35'd50, 32'd60, 8'h56);
      while (start_count == s0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      repeat (5) @(negedge clk);
      chk_cnt++; if (bus.pending !== 3'd1) $display("FAIL rmj_pending_before: %0d, required 1", bus.pending); else pass_cnt++;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_cnt++; if (bus.start !== 1'b0 || bus.cpl_valid !== 1'b0)
         $display("FAIL rmj_outputs: start=%b cpl_valid=%b, required 0/0", bus.start, bus.cpl_valid); else pass_cnt++;
      chk_cnt++; if (bus.pending !== 3'd0 || bus.job_ready !== 1'b1)
         $display("FAIL rmj_fifo: pending=%0d ready=%b, required 0/1", bus.pending, bus.job_ready); else pass_cnt++;
      @(negedge clk);
      rst      = 1'b0;
      core_lat = 5;
      enq(64'h7200, 64'hD200, 35'd70, 32'd80, 8'h66);
      wait_cpl(b + 1);
      repeat (20) @(negedge clk);
      chk_cnt++; if (tag_q.size() !== b + 1 || tag_q[b] !== 8'h66 || sts_q[b] !== 2'd0)
         $display("FAIL rmj_fresh: count=%0d tag=%02h sts=%0d, required %0d/66/0", tag_q.size() - b, tag_q[b], sts_q[b], 1);
      else pass_cnt++;
   endtask

`ifdef JOB_TIMEOUT_EN
   task automatic test_timeout();
      int b = tag_q.size();
      int a0 = abort_count;
      core_lat = 0;
      enq(64'h8000, 64'hE000, 35'd16, 32'd32, 8'h77);
      wait_cpl(b + 1);
      chk_cnt++; if (abort_count - a0 !== 1) $display("FAIL tmo_abort_count: %0d, required 1", abort_count - a0); else pass_cnt++;
      chk_cnt++; if (abort_cyc - start_cyc !== 64) $display("FAIL tmo_abort_cycle: RUN cycle %0d, required 64", abort_cyc - start_cyc); else pass_cnt++;
      chk_cnt++; if (tag_q[b] !== 8'h77 || sts_q[b] !== 2'd2)
         $display("FAIL tmo_cpl: tag=%02h sts=%0d, required 77/2", tag_q[b], sts_q[b]); else pass_cnt++;
      core_lat = 63;
      enq(64'h8100, 64'hE100, 35'd16, 32'd32, 8'h78);
      wait_cpl(b + 2);
      chk_cnt++; if (abort_count - a0 !== 1) $display("FAIL tmo_done_wins_abort: %0d, required 1", abort_count - a0); else pass_cnt++;
      chk_cnt++; if (tag_q[b+1] !== 8'h78 || sts_q[b+1] !== 2'd0)
         $display("FAIL tmo_done_wins_cpl: tag=%02h sts=%0d, required 78/0", tag_q[b+1], sts_q[b+1]); else pass_cnt++;
   endtask
`endif

   initial begin
      bus.job_valid      = 1'b0;
      bus.job_src_addr   = '0;
      bus.job_des_addr   = '0;
      bus.job_comp_len   = '0;
      bus.job_decomp_len = '0;
      bus.job_tag        = '0;
      bus.cpl_ready      = 1'b1;
      core_hold          = 1'b0;
      core_lat           = 10;
      test_reset();
      test_single_job();
      test_back_to_back();
      test_zero_len();
      test_backpressure();
      test_reset_mid_job();
`ifdef JOB_TIMEOUT_EN
      test_timeout();
`endif
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit, required completion");
      $fatal(1);
   end
endmodule
